// File: rtl/priority_lock_pkg.sv
// priority_lock_pkg: FSM state and priority-mode encodings shared by the lock arbiter.
package priority_lock_pkg;
   typedef enum logic {PLA_IDLE, PLA_LOCKED} pla_state_e;
   localparam int MODE_FIXED = 0;
   localparam int MODE_RR = 1;
endpackage

// File: rtl/pla_prio_pick.sv
// pla_prio_pick: first set bit of vec searching downward from start, wrapping past 0 to N-1.
module pla_prio_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         vec,
   input  logic [$clog2(N)-1:0] start,
   output logic                 found,
   output logic [N-1:0]         onehot,
   output logic [$clog2(N)-1:0] idx
);
   localparam int IW = $clog2(N);
   int p;
   always_comb begin
      found = 1'b0;
      idx = '0;
      p = 0;
      for (int k = N - 1; k >= 0; k--) begin
         p = (int'(start) - k + N) % N;
         if (vec[p]) begin
            found = 1'b1;
            idx = IW'(p);
         end
      end
      onehot = found ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/priority_lock_arbiter.sv
// priority_lock_arbiter: N-way registered arbiter whose grant stays locked while the owner holds req.
// Define PLA_TIMEOUT_EN to force release after TIMEOUT_CYC locked cycles and ban the owner until it drops req.
module priority_lock_arbiter
   import priority_lock_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int MODE        = 0,
   parameter int CNT_W       = 8,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req,
   output logic [NUM_REQ-1:0]         grant,
   output logic                       grant_valid,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic [CNT_W-1:0]           hold_cnt,
   output logic                       timeout
);
   localparam int IW = $clog2(NUM_REQ);
   pla_state_e state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d, cand, pick_oh;
   logic [IW-1:0] id_q, id_d, rr_q, rr_d, start, pick_idx;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic pick_found, owner_req, expire, take, keep;
   assign owner_req = req[id_q];
   assign start = (MODE == MODE_RR && rr_q != '0) ? rr_q - 1'b1 : IW'(NUM_REQ - 1);
`ifdef PLA_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
   logic [NUM_REQ-1:0] ban_q, ban_d;
   logic timeout_q;
   assign cand = req & ~ban_q;
   assign ban_d = (ban_q & req) | (expire ? grant_q : '0);
   assign timeout = timeout_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ban_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         ban_q <= ban_d;
         timeout_q <= expire;
      end
   end
`else
   localparam bit TMO_EN = 1'b0;
   assign cand = req;
   assign timeout = 1'b0;
`endif
   assign expire = TMO_EN && state_q == PLA_LOCKED && owner_req && hold_q == CNT_W'(TIMEOUT_CYC);
   pla_prio_pick #(.N(NUM_REQ)) u_pick (
      .vec(cand),
      .start(start),
      .found(pick_found),
      .onehot(pick_oh),
      .idx(pick_idx)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PLA_IDLE;
         grant_q <= '0;
         id_q <= '0;
         rr_q <= '0;
         hold_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         id_q <= id_d;
         rr_q <= rr_d;
         hold_q <= hold_d;
      end
   end
   always_comb begin
      state_d = (state_q == PLA_IDLE) ? (pick_found ? PLA_LOCKED : PLA_IDLE)
                                      : ((!owner_req || expire) ? PLA_IDLE : PLA_LOCKED);
   end
   // Anything other than taking or keeping a lock returns every output to zero.
   always_comb begin
      take = state_q == PLA_IDLE && pick_found;
      keep = state_q == PLA_LOCKED && owner_req && !expire;
      grant_d = take ? pick_oh : keep ? grant_q : '0;
      id_d = take ? pick_idx : keep ? id_q : '0;
      hold_d = take ? CNT_W'(1) : keep ? (&hold_q ? hold_q : hold_q + 1'b1) : '0;
      rr_d = take ? pick_idx : rr_q;
   end
   assign grant = grant_q;
   assign grant_valid = |grant_q;
   assign grant_id = id_q;
   assign hold_cnt = hold_q;
endmodule

// File: tb/tb_priority_lock_arbiter.sv
// tb_priority_lock_arbiter: directed stimulus on fixed, round-robin and 7-way arbiters with a grant scoreboard.
module tb_priority_lock_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;
   logic [3:0] req_a, grant_a, req_b, grant_b;
   logic [6:0] req_c, grant_c;
   logic [1:0] id_a, id_b;
   logic [2:0] id_c, hc_a;
   logic [7:0] hc_b, hc_c;
   logic gv_a, gv_b, gv_c, to_a, to_b, to_c;
   logic [15:0] q_a[$], q_b[$], q_c[$];
   int total = 0;
   int bad = 0;
   priority_lock_arbiter #(.NUM_REQ(4), .MODE(0), .CNT_W(3), .TIMEOUT_CYC(5)) u_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .grant(grant_a), .grant_valid(gv_a),
      .grant_id(id_a), .hold_cnt(hc_a), .timeout(to_a));
   priority_lock_arbiter #(.NUM_REQ(4), .MODE(1), .CNT_W(8), .TIMEOUT_CYC(16)) u_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .grant(grant_b), .grant_valid(gv_b),
      .grant_id(id_b), .hold_cnt(hc_b), .timeout(to_b));
   priority_lock_arbiter #(.NUM_REQ(7), .MODE(1), .CNT_W(8), .TIMEOUT_CYC(16)) u_c (
      .clk(clk), .rst_n(rst_n), .req(req_c), .grant(grant_c), .grant_valid(gv_c),
      .grant_id(id_c), .hold_cnt(hc_c), .timeout(to_c));
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
      end
   endtask
   task automatic nxt;
      @(negedge clk);
   endtask
   // Monitor: every new nonzero grant pops the next expected {grant, id} of that arbiter.
   initial begin
      logic [3:0] pa = '0, pb = '0;
      logic [6:0] pc = '0;
      logic [15:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (rst_n && grant_a != pa && grant_a != '0) begin
            if (q_a.size() == 0) chk("a_unexpected", 32'(grant_a), 0);
            else begin
               e = q_a.pop_front();
               chk("a_grant", 32'(grant_a), 32'(e[15:8]));
               chk("a_id", 32'(id_a), 32'(e[7:0]));
            end
         end
         if (rst_n && grant_b != pb && grant_b != '0) begin
            if (q_b.size() == 0) chk("b_unexpected", 32'(grant_b), 0);
            else begin
               e = q_b.pop_front();
               chk("b_grant", 32'(grant_b), 32'(e[15:8]));
               chk("b_id", 32'(id_b), 32'(e[7:0]));
            end
         end
         if (rst_n && grant_c != pc && grant_c != '0) begin
            if (q_c.size() == 0) chk("c_unexpected", 32'(grant_c), 0);
            else begin
               e = q_c.pop_front();
               chk("c_grant", 32'(grant_c), 32'(e[15:8]));
               chk("c_id", 32'(id_c), 32'(e[7:0]));
            end
         end
         pa = rst_n ? grant_a : '0;
         pb = rst_n ? grant_b : '0;
         pc = rst_n ? grant_c : '0;
      end
   end
   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end
   initial begin
      int ord[4] = '{'b0100, 'b0010, 'b0001, 'b1000};
      int ordid[4] = '{2, 1, 0, 3};
      int prev, owner, nid;
      req_a = '0;
      req_b = '0;
      req_c = '0;
      nxt;
      nxt;
      chk("rst_grant", 32'(grant_a), 0);
      chk("rst_valid", 32'(gv_a), 0);
      chk("rst_id", 32'(id_a), 0);
      chk("rst_hold", 32'(hc_a), 0);
      chk("rst_timeout", 32'(to_a), 0);
      chk("rst_grant_c", 32'(grant_c), 0);
      rst_n = 1'b1;
      req_a = 4'b0100;
      q_a.push_back({8'h04, 8'd2});
      nxt;
      chk("t1_grant", 32'(grant_a), 'b0100);
      chk("t1_hold1", 32'(hc_a), 1);
      nxt;
      chk("t1_hold2", 32'(hc_a), 2);
      #3 rst_n = 1'b0;
      #1;
      chk("t1_async_grant", 32'(grant_a), 0);
      chk("t1_async_valid", 32'(gv_a), 0);
      chk("t1_async_id", 32'(id_a), 0);
      chk("t1_async_hold", 32'(hc_a), 0);
      chk("t1_async_timeout", 32'(to_a), 0);
      nxt;
      rst_n = 1'b1;
      q_a.push_back({8'h04, 8'd2});
      nxt;
      chk("t1_regrant", 32'(grant_a), 'b0100);
      chk("t1_regrant_hold", 32'(hc_a), 1);
      req_a = '0;
      nxt;
      chk("t1_release", 32'(grant_a), 0);
      chk("t1_release_hold", 32'(hc_a), 0);
      req_a = 4'b0011;
      q_a.push_back({8'h02, 8'd1});
      nxt;
      chk("t2_grant", 32'(grant_a), 'b0010);
      chk("t2_hold1", 32'(hc_a), 1);
      req_a = 4'b1011;
      nxt;
      chk("t2_locked", 32'(grant_a), 'b0010);
      chk("t2_locked_id", 32'(id_a), 1);
      nxt;
      chk("t2_locked2", 32'(grant_a), 'b0010);
      chk("t2_hold3", 32'(hc_a), 3);
      req_a = 4'b1001;
      q_a.push_back({8'h08, 8'd3});
      nxt;
      chk("t2_gap", 32'(grant_a), 0);
      chk("t2_gap_valid", 32'(gv_a), 0);
      nxt;
      chk("t2_next", 32'(grant_a), 'b1000);
      chk("t2_next_id", 32'(id_a), 3);
      chk("t2_next_hold", 32'(hc_a), 1);
`ifndef PLA_TIMEOUT_EN
      for (int k = 2; k <= 10; k++) begin
         nxt;
         chk("t4_hold", 32'(hc_a), k > 7 ? 7 : k);
         chk("t4_keep", 32'(grant_a), 'b1000);
         chk("t4_no_timeout", 32'(to_a), 0);
      end
`endif
      req_a = '0;
      nxt;
      chk("t4_clr_hold", 32'(hc_a), 0);
      chk("t4_clr_valid", 32'(gv_a), 0);
`ifdef PLA_TIMEOUT_EN
      req_a = 4'b0001;
      q_a.push_back({8'h01, 8'd0});
      nxt;
      chk("t5_grant", 32'(grant_a), 'b0001);
      chk("t5_hold1", 32'(hc_a), 1);
      for (int k = 2; k <= 5; k++) begin
         nxt;
         chk("t5_hold", 32'(hc_a), k);
         chk("t5_keep", 32'(grant_a), 'b0001);
         chk("t5_no_pulse", 32'(to_a), 0);
      end
      nxt;
      chk("t5_pulse", 32'(to_a), 1);
      chk("t5_forced", 32'(grant_a), 0);
      nxt;
      chk("t5_pulse_end", 32'(to_a), 0);
      chk("t5_banned", 32'(grant_a), 0);
      nxt;
      chk("t5_banned2", 32'(grant_a), 0);
      req_a = '0;
      nxt;
      req_a = 4'b0001;
      q_a.push_back({8'h01, 8'd0});
      nxt;
      chk("t5_regrant", 32'(grant_a), 'b0001);
      req_a = '0;
      nxt;
`endif
      req_b = 4'hf;
      q_b.push_back({8'h08, 8'd3});
      nxt;
      chk("t3_first", 32'(grant_b), 'b1000);
      nxt;
      prev = 'b1000;
      for (int i = 0; i < 4; i++) begin
         req_b = 4'hf & ~4'(prev);
         q_b.push_back({8'(ord[i]), 8'(ordid[i])});
         nxt;
         chk("t3_gap", 32'(grant_b), 0);
         req_b = 4'hf;
         nxt;
         chk("t3_order", 32'(grant_b), ord[i]);
         nxt;
         chk("t3_held", 32'(grant_b), ord[i]);
         prev = ord[i];
      end
      req_b = '0;
      nxt;
      req_c = 7'b1000001;
      q_c.push_back({8'h40, 8'd6});
      nxt;
      chk("t6_id_first", 32'(id_c), 6);
      nxt;
      chk("t6_id_first2", 32'(id_c), 6);
      owner = 6;
      for (int i = 0; i < 4; i++) begin
         nid = (owner == 6) ? 0 : 6;
         req_c = 7'b1000001 & ~(7'(1) << owner);
         q_c.push_back({8'(1 << nid), 8'(nid)});
         nxt;
         chk("t6_gap_valid", 32'(gv_c), 0);
         chk("t6_gap_id", 32'(id_c), 0);
         req_c = 7'b1000001;
         nxt;
         chk("t6_id", 32'(id_c), nid);
         chk("t6_grant", 32'(grant_c), 1 << nid);
         nxt;
         chk("t6_id_held", 32'(id_c), nid);
         owner = nid;
      end
      req_c = '0;
      nxt;
      nxt;
      chk("sb_a_drained", q_a.size(), 0);
      chk("sb_b_drained", q_b.size(), 0);
      chk("sb_c_drained", q_c.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
